pte_mem_responder: RTL and testbench
====================================

PTE_MEM_RESPONDER -- requirements
Module: pte_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 48-bit PTE words stored (power of two).
REQ-002 SHALL have parameter WIDTH, default 48, PTE and address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_addr  input  48  PTE byte address from page table walker.
REQ-006 SHALL have port mem_read  input  1  level request from walker, held while walk level pending.
REQ-007 SHALL have port mem_data  output  48  returned PTE, valid only while mem_ready=1.
REQ-008 SHALL have port mem_ready  output  1  one-cycle response strobe.
REQ-009 SHALL have port window_base  input  48  byte address of PTE word 0.
REQ-010 SHALL have port latency  input  4  extra wait cycles per response, 0..15.
REQ-011 SHALL have port cfg_we  input  1  table preload write strobe.
REQ-012 SHALL have port cfg_index  input  log2(DEPTH)  preload word index.
REQ-013 SHALL have port cfg_wdata  input  48  preload data.
REQ-014 SHALL have port busy  output  1  high in WAIT or RESP.
REQ-015 SHALL have port req_count  output  32  accepted requests.
REQ-016 SHALL have port err_count  output  32  out-of-range or misaligned requests.

Function
REQ-017 SHALL implement states IDLE, WAIT, RESP.
REQ-018 IDLE and mem_read=1 at an edge: SHALL accept; capture address, response data, latency; go WAIT with counter=latency, or RESP directly if latency=0.
REQ-019 WAIT: counter decrements each cycle; at counter=1 SHALL go RESP next edge; so mem_ready rises L+1 cycles after acceptance edge.
REQ-020 RESP: mem_ready=1 and mem_data=captured data for exactly one cycle; SHALL return to IDLE next edge regardless of mem_read.
REQ-021 mem_data SHALL be 0 whenever mem_ready=0; both outputs registered.
REQ-022 After RESP, at least one IDLE cycle; a still-high mem_read (new walk level address) SHALL be accepted as a new request from IDLE.
REQ-023 In range: mem_addr >= window_base and (mem_addr - window_base) < DEPTH*8, unsigned 48-bit; index = offset>>3.
REQ-024 Out-of-range or mem_addr[2:0]!=0: response data SHALL be 0 (valid bit 3 clear, walker faults); err_count increments at acceptance; timing unchanged.
REQ-025 mem_read low in WAIT: SHALL abort to IDLE next edge, no mem_ready pulse; counts already made stand.
REQ-026 mem_addr changes during WAIT/RESP SHALL be ignored (captured address used).
REQ-027 cfg_we writes cfg_wdata to cfg_index at the edge in any state.
REQ-028 cfg_we same edge as acceptance, same index: response SHALL return old data (read-before-write); writes during WAIT do not alter captured data.
REQ-029 req_count increments once per acceptance; both counters saturate at 0xFFFFFFFF.
REQ-030 latency changes after acceptance SHALL not affect the pending request.

Reset
REQ-031 reset SHALL force IDLE, mem_ready=0, mem_data=0, busy=0, req_count=0, err_count=0, counter=0, asynchronously, including mid-WAIT/RESP.
REQ-032 Table storage SHALL not be cleared by reset; bench preloads via cfg port.
REQ-033 First acceptance possible at first edge after reset deasserts.

Verification
REQ-034 Preload idx5=0x20000000200F, window_base=0x1000, latency=2, mem_read with addr 0x1028 -> mem_ready one cycle, 3 cycles after acceptance, mem_data=0x20000000200F, req_count=1.
REQ-035 Walker sequence: three levels, addresses 0x1000/0x1008/0x1010 (preloaded 0xA,0xB,0xC), mem_read held high, address updated on each ready -> three single ready pulses with 0xA,0xB,0xC, one IDLE cycle between, req_count=3.
REQ-036 addr 0x0FF8 then 0x1004 (latency 0) -> mem_ready 1 cycle after each acceptance, mem_data=0, err_count=2.
REQ-037 latency=5, drop mem_read 2 cycles after acceptance -> no mem_ready, busy low next cycle, req_count=1.
REQ-038 cfg_we idx0=0x5 same edge as acceptance of addr 0x1000 (old 0x9) -> response 0x9; next request returns 0x5.
REQ-039 Assert reset in WAIT with req_count=4 -> mem_ready=0, busy=0, counters 0 immediately; no ready after release without new request.

Source files
------------

// File: rtl/pte_mem_responder.sv
// pte_mem_responder: PTE table memory answering page-walker reads after a programmable latency
// Ports: clk/reset (async, active-high); mem_addr/mem_read in and mem_data/mem_ready out form the walker port;
// window_base maps PTE word 0; latency adds wait cycles; cfg_we/cfg_index/cfg_wdata preload the table;
// busy flags a pending request; req_count/err_count count accepted and faulting requests (saturating).
module pte_mem_responder #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         mem_addr,
    input  logic                     mem_read,
    output logic [WIDTH-1:0]         mem_data,
    output logic                     mem_ready,
    input  logic [WIDTH-1:0]         window_base,
    input  logic [3:0]               latency,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_index,
    input  logic [WIDTH-1:0]         cfg_wdata,
    output logic                     busy,
    output logic [31:0]              req_count,
    output logic [31:0]              err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] SPAN = WIDTH'(DEPTH * 8);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, next_state;
    logic [3:0] cnt, next_cnt;
    logic [WIDTH-1:0] data_q, next_data, offset;
    logic [WIDTH-1:0] pte_mem [DEPTH];
    logic accept, hit;
    assign offset = mem_addr - window_base;
    assign hit = mem_addr >= window_base && offset < SPAN && mem_addr[2:0] == 3'd0;
    assign busy = state != IDLE;
    // The table read is taken before this edge's cfg write lands, so a same-edge write is not seen
    always_comb begin
        next_state = state;
        next_cnt = cnt;
        accept = 1'b0;
        unique case (state)
            IDLE: begin
                accept = mem_read;
                next_state = !mem_read ? IDLE : latency == 4'd0 ? RESP : WAIT;
                next_cnt = mem_read ? latency : cnt;
            end
            WAIT: begin
                next_state = !mem_read ? IDLE : cnt == 4'd1 ? RESP : WAIT;
                next_cnt = mem_read ? cnt - 4'd1 : 4'd0;
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        next_data = accept ? (hit ? pte_mem[offset[AW+2:3]] : '0) : data_q;
    end
    // Outputs are registered from the next state so mem_ready/mem_data line up with RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            data_q <= '0;
            mem_ready <= 1'b0;
            mem_data <= '0;
            req_count <= 32'd0;
            err_count <= 32'd0;
        end else begin
            state <= next_state;
            cnt <= next_cnt;
            data_q <= next_data;
            mem_ready <= next_state == RESP;
            mem_data <= next_state == RESP ? next_data : '0;
            req_count <= accept && req_count != '1 ? req_count + 32'd1 : req_count;
            err_count <= accept && !hit && err_count != '1 ? err_count + 32'd1 : err_count;
        end
    end
    always_ff @(posedge clk) begin
        if (cfg_we) pte_mem[cfg_index] <= cfg_wdata;
    end
endmodule

// File: tb/tb_pte_mem_responder.sv
// tb_pte_mem_responder: scoreboard bench for pte_mem_responder with a behavioural table model
module tb_pte_mem_responder;
    localparam int DEPTH = 256;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [47:0] mem_addr = '0;
    logic mem_read = 1'b0;
    logic [47:0] mem_data;
    logic mem_ready;
    logic [47:0] window_base = 48'h1000;
    logic [3:0] latency = 4'd0;
    logic cfg_we = 1'b0;
    logic [7:0] cfg_index = '0;
    logic [47:0] cfg_wdata = '0;
    logic busy;
    logic [31:0] req_count, err_count;

    pte_mem_responder #(.DEPTH(DEPTH), .WIDTH(48)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_data(mem_data), .mem_ready(mem_ready), .window_base(window_base),
        .latency(latency), .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_wdata(cfg_wdata),
        .busy(busy), .req_count(req_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] d;
        int c;
    } exp_t;
    exp_t sb[$];
    logic [47:0] mdl [DEPTH];
    logic [47:0] base = 48'h1000;
    int checks = 0, failures = 0;
    int m_req = 0, m_err = 0, idle_from = 0;

    task automatic chk(input string n, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic check_counts(input string t);
        chk({t, "_req_count"}, 48'(req_count), 48'(m_req));
        chk({t, "_err_count"}, 48'(err_count), 48'(m_err));
    endtask

    task automatic cfg(input logic [7:0] i, input logic [47:0] d);
        cfg_we = 1'b1;
        cfg_index = i;
        cfg_wdata = d;
        mdl[i] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Monitor: every presented response is popped and compared against the queued expectation
    always @(negedge clk) begin
        if (mem_ready === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_ready", 48'd1, 48'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", mem_data, e.d);
                chk("resp_cycle", 48'(cyc), 48'(e.c));
                chk("busy_in_resp", 48'(busy), 48'd1);
            end
        end else chk("data_zero_when_not_ready", mem_data, 48'd0);
    end

    // One request: acceptance edge, expected response and its cycle come from the table model.
    // ab >= 0 drops mem_read ab cycles after acceptance; hold keeps mem_read high for a chained request.
    task automatic issue(input logic [47:0] a, input logic [3:0] l, input int ab, input bit hold,
                         input bit we, input logic [7:0] wi, input logic [47:0] wd);
        int acc;
        logic ok;
        logic [47:0] e;
        acc = (cyc > idle_from ? cyc : idle_from) + 1;
        mem_addr = a;
        latency = l;
        mem_read = 1'b1;
        while (cyc < acc - 1) @(negedge clk);
        cfg_we = we;
        cfg_index = wi;
        cfg_wdata = wd;
        ok = a >= base && (a - base) < 48'(DEPTH * 8) && a[2:0] == 3'd0;
        e = ok ? mdl[8'((a - base) >> 3)] : 48'd0;
        m_req++;
        if (!ok) m_err++;
        if (ab < 0) sb.push_back('{e, acc + int'(l)});
        @(negedge clk);
        if (we) mdl[wi] = wd;
        cfg_we = 1'b0;
        mem_addr = 48'({$urandom, $urandom});
        latency = 4'($urandom);
        if (l >= 2 && ab != 0 && $urandom_range(1) == 1) begin
            cfg_we = 1'b1;
            cfg_index = 8'($urandom);
            cfg_wdata = 48'({$urandom, $urandom});
            mdl[cfg_index] = cfg_wdata;
            @(negedge clk);
            cfg_we = 1'b0;
        end
        if (ab >= 0) begin
            while (cyc < acc + ab) @(negedge clk);
            chk("busy_before_abort", 48'(busy), 48'd1);
            mem_read = 1'b0;
            @(negedge clk);
            chk("busy_after_abort", 48'(busy), 48'd0);
            idle_from = cyc;
        end else begin
            while (cyc < acc + int'(l)) @(negedge clk);
            if (!hold) mem_read = 1'b0;
            idle_from = acc + int'(l) + 1;
        end
    endtask

    initial begin
        int r, ab, acc;
        logic [3:0] l;
        logic [47:0] a;
        bit hold;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) cfg(8'(i), 48'({$urandom, $urandom}));
        cfg(8'd5, 48'h20000000200F);
        cfg(8'd0, 48'hA);
        cfg(8'd1, 48'hB);
        cfg(8'd2, 48'hC);
        chk("reset_ready", 48'(mem_ready), 48'd0);
        chk("reset_data", mem_data, 48'd0);
        chk("reset_busy", 48'(busy), 48'd0);
        check_counts("reset");
        reset = 1'b0;
        issue(48'h1028, 4'd2, -1, 0, 0, 8'd0, 48'd0);
        chk("basic_req_count", 48'(req_count), 48'd1);
        issue(48'h1000, 4'd1, -1, 1, 0, 8'd0, 48'd0);
        issue(48'h1008, 4'd0, -1, 1, 0, 8'd0, 48'd0);
        issue(48'h1010, 4'd3, -1, 0, 0, 8'd0, 48'd0);
        check_counts("walk");
        issue(48'h0FF8, 4'd0, -1, 0, 0, 8'd0, 48'd0);
        issue(48'h1004, 4'd0, -1, 0, 0, 8'd0, 48'd0);
        check_counts("range_err");
        issue(48'h1000, 4'd5, 2, 0, 0, 8'd0, 48'd0);
        check_counts("abort");
        cfg(8'd0, 48'h9);
        issue(48'h1000, 4'd1, -1, 0, 1, 8'd0, 48'h5);
        issue(48'h1000, 4'd1, -1, 0, 0, 8'd0, 48'd0);
        check_counts("rbw");
        base = 48'({$urandom, $urandom}) & 48'hFFFF_FFFF_F000 | 48'h1_0000;
        window_base = base;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(9);
            a = r < 6 ? base + 48'(8 * $urandom_range(255)) :
                r == 6 ? base + 48'(8 * $urandom_range(255) + $urandom_range(1, 7)) :
                r == 7 ? base - 48'(8 * $urandom_range(1, 100)) :
                r == 8 ? base + 48'(2048 + 8 * $urandom_range(100)) :
                base + 48'($urandom_range(1) == 1 ? 2040 : 2048);
            l = $urandom_range(19) == 0 ? 4'd15 : 4'($urandom_range(6));
            ab = (l > 0 && $urandom_range(3) == 0) ? int'($urandom_range(int'(l) - 1)) : -1;
            hold = ab < 0 && i < 199 && $urandom_range(1) == 1;
            issue(a, l, ab, hold, $urandom_range(3) == 0, 8'($urandom), 48'({$urandom, $urandom}));
            if (!hold) repeat ($urandom_range(2)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check_counts("random");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_req = 0;
        m_err = 0;
        idle_from = cyc;
        issue(base, 4'd1, -1, 0, 0, 8'd0, 48'd0);
        issue(base + 48'd8, 4'd0, -1, 0, 0, 8'd0, 48'd0);
        issue(base + 48'd3, 4'd2, -1, 0, 0, 8'd0, 48'd0);
        while (cyc < idle_from) @(negedge clk);
        mem_addr = base + 48'd16;
        latency = 4'd5;
        mem_read = 1'b1;
        m_req++;
        acc = cyc + 1;
        while (cyc < acc + 1) @(negedge clk);
        chk("busy_in_wait", 48'(busy), 48'd1);
        check_counts("pre_reset");
        reset = 1'b1;
        #1;
        chk("midwait_reset_ready", 48'(mem_ready), 48'd0);
        chk("midwait_reset_data", mem_data, 48'd0);
        chk("midwait_reset_busy", 48'(busy), 48'd0);
        m_req = 0;
        m_err = 0;
        check_counts("midwait_reset");
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_counts("post_reset");
        chk("scoreboard_empty", 48'(sb.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
